dcache_ram_be: RTL and testbench
================================

# dcache_ram_be

Parametrised single-clock RAM for the dcache2 data and tag arrays, with one read port and one write port. Reads are registered, writes use per-byte lane enables, and a same-address read and write in the same cycle forward the new data. After reset, an internal sweep zeroes every entry before the block reports ready, so cache lines never start with stale contents.

## Interface
- DATABITS, 32, word width; must be a multiple of 8.
- ADDRBITS, 5, address width.
- MEMSIZE, 2**ADDRBITS, number of entries; must not be overridden independently.
- LANES, DATABITS/8, number of byte lanes; derived, not overridden.
- CLEAR_ON_RESET, 1, 1 = zero-sweep after reset; 0 = skip the sweep, contents undefined.

- clk  in  1  clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  read request.
- rd_addr  in  ADDRBITS  read address.
- rd_data  out  DATABITS  registered read data.
- rd_valid  out  1  rd_data updated this cycle.
- wr_en  in  1  write request.
- wr_addr  in  ADDRBITS  write address.
- wr_data  in  DATABITS  write data.
- wr_be  in  LANES  byte enables; bit i covers wr_data[8i+7:8i].
- ready  out  1  sweep complete; port accepts traffic.

## Operation
- The design has one clock domain. Reset is asynchronous and active-low.
- Reset state: ready=0, rd_valid=0, rd_data=0, sweep counter=0, FSM=CLEAR (or READY_WAIT when CLEAR_ON_RESET=0). The memory array is not reset.
- FSM states and transitions:
  - CLEAR: each edge writes all-zero to mem[counter], all lanes. Counter increments. On counter==MEMSIZE-1 the FSM moves to READY and the counter wraps to 0.
  - READY_WAIT (CLEAR_ON_RESET=0 only): moves to READY on the first edge after reset release.
  - READY: normal traffic. There is no exit except reset.
- While ready=0: rd_en and wr_en are ignored, rd_valid stays 0, and user writes are dropped (not queued).
- Write in READY: for each i with wr_be[i]=1, mem[wr_addr] lane i <= wr_data lane i. Other lanes keep their value. wr_be=0 with wr_en=1 is a no-op.
- Read in READY: rd_data <= mem[rd_addr], and rd_valid is 1 in the following cycle.
- Without rd_en, rd_data holds its last value and rd_valid=0.
- Read-during-write at the same address (write-first): each lane with wr_be=1 returns wr_data for that lane. Each lane with wr_be=0 returns the old contents.
- Read-during-write at different addresses: the two operations are independent.
- Reset asserted mid-sweep or mid-traffic: outputs return to reset values immediately and the sweep restarts from address 0 after release.

## Timing
- Read latency is 1 cycle: rd_en sampled at edge N, rd_data/rd_valid valid after edge N, until edge N+1.
- A write is visible to a read issued on the same edge through forwarding. It is visible from the array on any later edge.
- Sweep duration is exactly MEMSIZE edges after reset release. ready rises after the MEMSIZE-th edge, so the first accepted request is at edge MEMSIZE+1.
- Throughput: one read and one write per cycle in READY. There are no stalls.
- The counter is ADDRBITS wide, and terminal-count detection is on MEMSIZE-1. There is no extra bit.

## Structure
- Package dcache2_pkg holds the FSM state constants (ST_CLEAR, ST_READY_WAIT, ST_READY) and the byte width constant 8 shared with the other dcache2 arrays.
- Sub-module dcache_ram_lane: 8-bit, 2**ADDRBITS-deep array with one write port and a registered read with write-first forwarding. The top instantiates it LANES times through generate.
- The top holds the sweep FSM and counter, and muxes the write port between sweep (zero, all lanes) and user traffic. It also generates rd_valid.

## Test plan
- Reset release, DATABITS=32, ADDRBITS=5 -> ready=0 for 32 edges, 1 after edge 32. Then reads of addresses 0, 17 and 31 return 0x00000000 with rd_valid one cycle after rd_en.
- Write 0xDEADBEEF to addr 5 with be=4'b1111, then be=4'b0101 data 0x11223344 -> read addr 5 returns 0xDE22BE44.
- Same-cycle wr_en+rd_en to addr 9: old 0xAAAAAAAA, write 0x55555555 be=4'b0011 -> rd_data=0xAAAA5555 next cycle.
- wr_en with wr_addr=3 asserted during sweep (edge 10) -> after ready, addr 3 reads 0.
- Fill addr 7 with 0x12345678, assert reset_n=0 mid-traffic, release -> rd_data=0 and rd_valid=0 immediately, ready low for 32 edges, then addr 7 reads 0.
- CLEAR_ON_RESET=0 -> ready=1 after the first edge post-release. A write then read of addr 31 round-trips 0xCAFEF00D at 1-cycle latency.

Source files
------------

// File: rtl/dcache2_pkg.sv
// Shared constants for the dcache2 RAM arrays: byte width and the
// power-up sweep FSM state encoding.
package dcache2_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_CLEAR      = 2'd0,
    ST_READY_WAIT = 2'd1,
    ST_READY      = 2'd2
  } ram_state_e;

endpackage

// File: rtl/dcache_ram_lane.sv
// One byte lane of the dcache2 RAM: one write port, one registered read port
// with write-first forwarding on a same-address collision.
module dcache_ram_lane
  import dcache2_pkg::*;
#(
  parameter int ADDRBITS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we,
  input  logic [ADDRBITS-1:0] waddr,
  input  logic [BYTE_W-1:0]   wdata,
  input  logic                re,
  input  logic [ADDRBITS-1:0] raddr,
  output logic [BYTE_W-1:0]   rdata
);

  localparam int DEPTH = 2**ADDRBITS;

  // Array has no reset; the top's sweep is what defines its contents.
  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rdata <= '0;
    else if (re)
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/dcache_ram_be.sv
// dcache2 data/tag RAM: byte-enabled write port, registered read port,
// zero-sweep of all entries after reset before traffic is accepted.
module dcache_ram_be
  import dcache2_pkg::*;
#(
  parameter int DATABITS       = 32,
  parameter int ADDRBITS       = 5,
  parameter int MEMSIZE        = 2**ADDRBITS,
  parameter int LANES          = DATABITS/BYTE_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rd_en,
  input  logic [ADDRBITS-1:0] rd_addr,
  output logic [DATABITS-1:0] rd_data,
  output logic                rd_valid,
  input  logic                wr_en,
  input  logic [ADDRBITS-1:0] wr_addr,
  input  logic [DATABITS-1:0] wr_data,
  input  logic [LANES-1:0]    wr_be,
  output logic                ready
);

  localparam ram_state_e RESET_ST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY_WAIT;
  localparam logic [ADDRBITS-1:0] LAST = ADDRBITS'(MEMSIZE-1);

  ram_state_e          state_q, state_d;
  logic [ADDRBITS-1:0] cnt_q, cnt_d;
  logic                clearing;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_ST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDRBITS'(1);
        if (cnt_q == LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY_WAIT: state_d = ST_READY;
      ST_READY:      state_d = ST_READY;
      default:       state_d = RESET_ST;
    endcase
  end

  assign clearing = (state_q == ST_CLEAR);
  assign ready    = (state_q == ST_READY);

  // Write port mux: the sweep owns it (zero, all lanes) until ready;
  // user writes arriving before then are simply dropped.
  logic [LANES-1:0]             lane_we;
  logic [ADDRBITS-1:0]          lane_waddr;
  logic [LANES-1:0][BYTE_W-1:0] lane_wdata;
  logic [LANES-1:0][BYTE_W-1:0] lane_rdata;
  logic                         lane_re;

  assign lane_we    = clearing ? {LANES{1'b1}} : ({LANES{ready & wr_en}} & wr_be);
  assign lane_waddr = clearing ? cnt_q : wr_addr;
  assign lane_wdata = clearing ? '0 : wr_data;
  assign lane_re    = ready & rd_en;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dcache_ram_lane #(
      .ADDRBITS(ADDRBITS)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .we     (lane_we[i]),
      .waddr  (lane_waddr),
      .wdata  (lane_wdata[i]),
      .re     (lane_re),
      .raddr  (rd_addr),
      .rdata  (lane_rdata[i])
    );
  end

  assign rd_data = lane_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_valid <= 1'b0;
    else          rd_valid <= lane_re;
  end

endmodule

// File: tb/tb_dcache_ram_be.sv
// Randomized + directed bench for dcache_ram_be against a word-level model.
module tb_dcache_ram_be;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NW = 2**AW;
  localparam int NL = DW/8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [NL-1:0] wr_be;
  logic          rd_valid, ready;

  logic          b_reset_n;
  logic          b_rd_en, b_wr_en;
  logic [AW-1:0] b_rd_addr, b_wr_addr;
  logic [DW-1:0] b_wr_data, b_rd_data;
  logic [NL-1:0] b_wr_be;
  logic          b_rd_valid, b_ready;

  always #5 clk = ~clk;

  dcache_ram_be #(.DATABITS(DW), .ADDRBITS(AW), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .ready(ready)
  );

  dcache_ram_be #(.DATABITS(DW), .ADDRBITS(AW), .CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .reset_n(b_reset_n),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
    .ready(b_ready)
  );

  // Reference model: word array, ready flag, edges seen since reset release.
  logic [DW-1:0] mem_m [NW];
  logic          rdy_m;
  int            edges_m;
  logic [DW-1:0] exp_data;
  logic          exp_valid;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input logic re, input int ra, input logic we, input int wa,
                     input logic [DW-1:0] wd, input logic [NL-1:0] be);
    rd_en = re; rd_addr = AW'(ra);
    wr_en = we; wr_addr = AW'(wa); wr_data = wd; wr_be = be;
  endtask

  task automatic model_reset();
    rdy_m = 1'b0; edges_m = 0; exp_data = '0; exp_valid = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs in place, then check.
  task automatic cyc();
    logic [DW-1:0] w;
    @(posedge clk);
    if (rdy_m) begin
      exp_valid = rd_en;
      if (rd_en) begin
        w = mem_m[rd_addr];
        if (wr_en && wr_addr == rd_addr)
          for (int i = 0; i < NL; i++) if (wr_be[i]) w[8*i +: 8] = wr_data[8*i +: 8];
        exp_data = w;
      end
      if (wr_en) begin
        w = mem_m[wr_addr];
        for (int i = 0; i < NL; i++) if (wr_be[i]) w[8*i +: 8] = wr_data[8*i +: 8];
        mem_m[wr_addr] = w;
      end
    end else begin
      exp_valid = 1'b0;
      edges_m++;
      if (edges_m == NW) begin
        rdy_m = 1'b1;
        for (int a = 0; a < NW; a++) mem_m[a] = '0;
      end
    end
    #1;
    chk("ready", {31'b0, ready}, {31'b0, rdy_m});
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, exp_valid});
    chk("rd_data", rd_data, exp_data);
  endtask

  initial begin
    for (int a = 0; a < NW; a++) mem_m[a] = 'x;
    model_reset();
    reset_n = 1'b0; b_reset_n = 1'b0;
    drv(0, 0, 0, 0, '0, '0);
    b_rd_en = 0; b_rd_addr = '0; b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0; b_wr_be = '0;
    #2;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_data", rd_data, 32'd0);
    #10 reset_n = 1'b1;

    // Sweep: traffic must be ignored, including a write to addr 3 at edge 10.
    for (int e = 1; e <= NW; e++) begin
      if (e == 10) drv(1, 3, 1, 3, 32'hFFFF_FFFF, 4'hF);
      else         drv($urandom_range(0, 1), $urandom_range(0, NW-1), 0, 0, '0, '0);
      cyc();
      if (e == NW-1) chk("ready_before_last", {31'b0, ready}, 32'd0);
    end
    chk("ready_after_sweep", {31'b0, ready}, 32'd1);

    drv(1, 0, 0, 0, '0, '0);  cyc(); chk("zero_a0", rd_data, 32'h0);
    drv(1, 17, 0, 0, '0, '0); cyc(); chk("zero_a17", rd_data, 32'h0);
    drv(1, 31, 0, 0, '0, '0); cyc(); chk("zero_a31", rd_data, 32'h0);
    chk("zero_valid", {31'b0, rd_valid}, 32'd1);
    drv(1, 3, 0, 0, '0, '0);  cyc(); chk("sweep_drop_a3", rd_data, 32'h0);
    drv(0, 0, 0, 0, '0, '0);  cyc(); chk("hold_data", rd_data, 32'h0);

    drv(0, 0, 1, 5, 32'hDEAD_BEEF, 4'b1111); cyc();
    drv(0, 0, 1, 5, 32'h1122_3344, 4'b0101); cyc();
    drv(1, 5, 0, 0, '0, '0); cyc(); chk("be_merge", rd_data, 32'hDE22_BE44);

    drv(0, 0, 1, 9, 32'hAAAA_AAAA, 4'b1111); cyc();
    drv(1, 9, 1, 9, 32'h5555_5555, 4'b0011); cyc(); chk("fwd_same_addr", rd_data, 32'hAAAA_5555);
    drv(1, 9, 0, 0, '0, '0); cyc(); chk("fwd_written", rd_data, 32'hAAAA_5555);
    drv(1, 9, 1, 9, 32'h0, 4'b0000); cyc(); chk("be_zero_noop", rd_data, 32'hAAAA_5555);

    // Random traffic with frequent same-address collisions.
    for (int n = 0; n < 400; n++) begin
      int wa;
      wa = $urandom_range(0, NW-1);
      drv($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, NW-1),
          $urandom_range(0, 1), wa, $urandom, NL'($urandom));
      cyc();
    end

    // Reset in the middle of traffic.
    drv(0, 0, 1, 7, 32'h1234_5678, 4'hF); cyc();
    drv(1, 7, 0, 0, '0, '0); cyc(); chk("fill_a7", rd_data, 32'h1234_5678);
    drv(1, 7, 1, 7, 32'h0BAD_0BAD, 4'hF);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_data", rd_data, 32'h0);
    chk("midrst_valid", {31'b0, rd_valid}, 32'd0);
    chk("midrst_ready", {31'b0, ready}, 32'd0);
    drv(0, 0, 0, 0, '0, '0);
    #2 reset_n = 1'b1;
    for (int e = 1; e <= NW; e++) begin
      drv($urandom_range(0, 1), 7, $urandom_range(0, 1), 7, $urandom, 4'hF);
      cyc();
    end
    drv(1, 7, 0, 0, '0, '0); cyc(); chk("rst_cleared_a7", rd_data, 32'h0);
    drv(0, 0, 0, 0, '0, '0); cyc();

    // CLEAR_ON_RESET=0 instance: ready one edge after release.
    #2;
    chk("nc_ready_in_rst", {31'b0, b_ready}, 32'd0);
    b_reset_n = 1'b1;
    #1;
    chk("nc_ready_pre_edge", {31'b0, b_ready}, 32'd0);
    @(posedge clk); #1;
    chk("nc_ready", {31'b0, b_ready}, 32'd1);
    b_wr_en = 1; b_wr_addr = 5'd31; b_wr_data = 32'hCAFE_F00D; b_wr_be = 4'hF;
    @(posedge clk); #1;
    chk("nc_no_valid", {31'b0, b_rd_valid}, 32'd0);
    b_wr_en = 0; b_rd_en = 1; b_rd_addr = 5'd31;
    @(posedge clk); #1;
    chk("nc_rd_data", b_rd_data, 32'hCAFE_F00D);
    chk("nc_rd_valid", {31'b0, b_rd_valid}, 32'd1);
    b_rd_en = 0;
    @(posedge clk); #1;
    chk("nc_valid_drop", {31'b0, b_rd_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
